// File: rtl/ring_osc_pkg.sv
// rtl/ring_osc_pkg.sv - shared state type and default constants for the ring oscillator sweeper
package ring_osc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GATE,
    ST_REPORT
  } sweep_state_t;

  localparam int DEF_NTAPS         = 8;
  localparam int DEF_SETTLE_CYCLES = 16;

endpackage

// File: rtl/osc_edge_sync.sv
// rtl/osc_edge_sync.sv - 2-flop synchronizer plus edge flop producing a rising-edge pulse for osc_in
module osc_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic osc_in,
  output logic osc_edge
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= osc_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign osc_edge = s2 & ~s3;

endmodule

// File: rtl/ring_osc_sweeper.sv
// rtl/ring_osc_sweeper.sv - steps ring taps, counts oscillator edges over a clk-gated window per tap
module ring_osc_sweeper
  import ring_osc_pkg::*;
#(
  parameter int NTAPS         = DEF_NTAPS,
  parameter int TAP_W         = 3,
  parameter int GATE_W        = 16,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              single,
  input  logic [TAP_W-1:0]  tap_sel_in,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              osc_in,
  output logic              osc_enable,
  output logic [TAP_W-1:0]  tap,
  output logic              busy,
  output logic              result_valid,
  output logic [TAP_W-1:0]  result_tap,
  output logic [CNT_W-1:0]  result_count,
  output logic              result_ovf,
  output logic              done
);

  localparam logic [GATE_W-1:0] SETTLE_LAST = GATE_W'(SETTLE_CYCLES - 1);
  localparam logic [TAP_W-1:0]  TAP_LAST    = TAP_W'(NTAPS - 1);

  sweep_state_t      state, state_nx;
  logic [GATE_W-1:0] timer;
  logic [GATE_W-1:0] gate_len;
  logic              single_q;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              ovf, ovf_nx;
  logic              osc_edge;
  logic              settle_end, gate_end, last_tap;
  logic [TAP_W-1:0]  start_tap;

  osc_edge_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .osc_in   (osc_in),
    .osc_edge (osc_edge)
  );

  assign settle_end = (timer == SETTLE_LAST);
  assign gate_end   = (timer == gate_len - GATE_W'(1));
  assign last_tap   = single_q | (tap == TAP_LAST);

  always_comb begin
    start_tap = '0;
    if (single) begin
      start_tap = (int'(tap_sel_in) >= NTAPS) ? TAP_LAST : tap_sel_in;
    end
  end

  // Saturating count; an edge seen while already at full scale marks overflow.
  always_comb begin
    cnt_nx = cnt;
    ovf_nx = ovf;
    if (osc_edge) begin
      if (&cnt) ovf_nx = 1'b1;
      else      cnt_nx = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start && !abort) state_nx = ST_SETTLE;
      ST_SETTLE: if (abort) state_nx = ST_IDLE;
                 else if (settle_end) state_nx = ST_GATE;
      ST_GATE:   if (abort) state_nx = ST_IDLE;
                 else if (gate_end) state_nx = ST_REPORT;
      ST_REPORT: if (abort || last_tap) state_nx = ST_IDLE;
                 else state_nx = ST_SETTLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  assign busy         = (state != ST_IDLE);
  assign osc_enable   = (state != ST_IDLE);
  assign result_valid = (state == ST_REPORT);
  assign done         = (state == ST_REPORT) && last_tap;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer        <= '0;
      gate_len     <= GATE_W'(1);
      single_q     <= 1'b0;
      tap          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      result_tap   <= '0;
      result_count <= '0;
      result_ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (start && !abort) begin
            single_q <= single;
            gate_len <= (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
            tap      <= start_tap;
          end
        end
        ST_SETTLE: begin
          if (settle_end) begin
            timer <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end else begin
            timer <= timer + GATE_W'(1);
          end
        end
        ST_GATE: begin
          cnt   <= cnt_nx;
          ovf   <= ovf_nx;
          timer <= timer + GATE_W'(1);
          // Capture includes an edge landing in the final gate cycle.
          if (gate_end && !abort) begin
            result_tap   <= tap;
            result_count <= cnt_nx;
            result_ovf   <= ovf_nx;
          end
        end
        ST_REPORT: begin
          timer <= '0;
          if (!abort && !last_tap) tap <= tap + TAP_W'(1);
        end
        default: timer <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_osc_sweeper.sv
// tb/tb_ring_osc_sweeper.sv - directed self-checking bench for ring_osc_sweeper
module tb_ring_osc_sweeper;

  localparam int NTAPS  = 8;
  localparam int TAP_W  = 4;
  localparam int GATE_W = 16;
  localparam int CNT_W  = 4;
  localparam int SETTLE = 16;

  logic              clk = 1'b0;
  logic              rst, start, abort, single, osc_in;
  logic [TAP_W-1:0]  tap_sel_in;
  logic [GATE_W-1:0] gate_cycles;
  logic              osc_enable, busy, result_valid, result_ovf, done;
  logic [TAP_W-1:0]  tap, result_tap;
  logic [CNT_W-1:0]  result_count;

  int checks = 0;
  int errors = 0;
  int osc_period = 0;
  bit sweep_osc = 1'b0;
  int v_cyc[$], v_tap[$], v_cnt[$], v_ovf[$], d_cyc[$];
  int busy_low;

  ring_osc_sweeper #(
    .NTAPS(NTAPS), .TAP_W(TAP_W), .GATE_W(GATE_W), .CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .single(single),
    .tap_sel_in(tap_sel_in), .gate_cycles(gate_cycles), .osc_in(osc_in),
    .osc_enable(osc_enable), .tap(tap), .busy(busy), .result_valid(result_valid),
    .result_tap(result_tap), .result_count(result_count), .result_ovf(result_ovf), .done(done)
  );

  always #5 clk = ~clk;

  // Oscillator stand-in: square wave, period in clk cycles, per-tap in sweep mode.
  initial begin
    int hc;
    int p;
    hc = 0;
    osc_in = 1'b0;
    forever begin
      @(negedge clk);
      p = sweep_osc ? 10 + 2 * int'(tap) : osc_period;
      if (p < 2) begin
        osc_in = 1'b0;
        hc = 0;
      end else begin
        hc++;
        if (hc >= p / 2) begin
          osc_in = ~osc_in;
          hc = 0;
        end
      end
    end
  end

  task automatic drive_start(input logic s, input int t, input int g);
    @(negedge clk);
    single      = s;
    tap_sel_in  = TAP_W'(t);
    gate_cycles = GATE_W'(g);
    start       = 1'b1;
  endtask

  task automatic collect(input int max_cyc, input int restart_at);
    v_cyc.delete(); v_tap.delete(); v_cnt.delete(); v_ovf.delete(); d_cyc.delete();
    busy_low = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (restart_at != 0 && c == restart_at) begin
        single = 1'b0; tap_sel_in = TAP_W'(2); gate_cycles = GATE_W'(7); start = 1'b1;
      end
      if (restart_at != 0 && c == restart_at + 1) start = 1'b0;
      if (result_valid) begin
        v_cyc.push_back(c); v_tap.push_back(int'(result_tap));
        v_cnt.push_back(int'(result_count)); v_ovf.push_back(int'(result_ovf));
      end
      if (done) d_cyc.push_back(c);
      if (!busy) begin
        busy_low = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int nvalid;
    nvalid = 0;
    osc_period = 6;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (result_valid) nvalid++;
    end
    checks++; if (nvalid !== 0) begin errors++; $display("FAIL reset_valid got %0d exp 0", nvalid); end
    checks++; if (osc_enable !== 1'b0) begin errors++; $display("FAIL reset_osc_enable got %0b exp 0", osc_enable); end
    checks++; if (tap !== '0) begin errors++; $display("FAIL reset_tap got %0d exp 0", tap); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    checks++; if (result_tap !== '0) begin errors++; $display("FAIL reset_result_tap got %0d exp 0", result_tap); end
    checks++; if (result_count !== '0) begin errors++; $display("FAIL reset_result_count got %0d exp 0", result_count); end
    checks++; if (result_ovf !== 1'b0) begin errors++; $display("FAIL reset_result_ovf got %0b exp 0", result_ovf); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    osc_period = 10;
    drive_start(1'b1, 5, 100);
    collect(300, 0);
    checks++; if (v_cyc.size() !== 1) begin errors++; $display("FAIL single_nvalid got %0d exp 1", v_cyc.size()); end
    if (v_cyc.size() == 1) begin
      checks++; if (v_cyc[0] !== 117) begin errors++; $display("FAIL single_valid_cycle got %0d exp 117", v_cyc[0]); end
      checks++; if (v_tap[0] !== 5) begin errors++; $display("FAIL single_tap got %0d exp 5", v_tap[0]); end
      checks++; if (v_cnt[0] !== 10) begin errors++; $display("FAIL single_count got %0d exp 10", v_cnt[0]); end
      checks++; if (v_ovf[0] !== 0) begin errors++; $display("FAIL single_ovf got %0d exp 0", v_ovf[0]); end
    end
    checks++; if (d_cyc.size() !== 1 || d_cyc[0] !== 117) begin errors++; $display("FAIL single_done got %0d pulses exp 1 at 117", d_cyc.size()); end
    checks++; if (busy_low !== 118) begin errors++; $display("FAIL single_busy_low got %0d exp 118", busy_low); end
  endtask

  task automatic test_sweep();
    int exp_cnt[8];
    exp_cnt = '{5, 4, 4, 3, 3, 2, 2, 2};
    sweep_osc = 1'b1;
    drive_start(1'b0, 6, 50);
    collect(700, 0);
    sweep_osc = 1'b0;
    checks++; if (v_cyc.size() !== 8) begin errors++; $display("FAIL sweep_nvalid got %0d exp 8", v_cyc.size()); end
    if (v_cyc.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        checks++; if (v_cyc[k] !== 67 * (k + 1)) begin errors++; $display("FAIL sweep_cycle[%0d] got %0d exp %0d", k, v_cyc[k], 67 * (k + 1)); end
        checks++; if (v_tap[k] !== k) begin errors++; $display("FAIL sweep_tap[%0d] got %0d exp %0d", k, v_tap[k], k); end
        checks++; if (v_cnt[k] < exp_cnt[k] - 1 || v_cnt[k] > exp_cnt[k] + 1) begin errors++; $display("FAIL sweep_count[%0d] got %0d exp %0d+-1", k, v_cnt[k], exp_cnt[k]); end
      end
    end
    checks++; if (d_cyc.size() !== 1 || d_cyc[0] !== 536) begin errors++; $display("FAIL sweep_done got %0d pulses exp 1 at 536", d_cyc.size()); end
    checks++; if (busy_low !== 537) begin errors++; $display("FAIL sweep_busy_low got %0d exp 537", busy_low); end
  endtask

  task automatic test_saturation();
    osc_period = 4;
    drive_start(1'b1, 0, 200);
    collect(300, 0);
    checks++; if (v_cyc.size() !== 1) begin errors++; $display("FAIL sat_nvalid got %0d exp 1", v_cyc.size()); end
    if (v_cyc.size() == 1) begin
      checks++; if (v_cnt[0] !== 15) begin errors++; $display("FAIL sat_count got %0d exp 15", v_cnt[0]); end
      checks++; if (v_ovf[0] !== 1) begin errors++; $display("FAIL sat_ovf got %0d exp 1", v_ovf[0]); end
    end
    repeat (10) @(negedge clk);
    checks++; if (result_count !== 4'd15 || result_ovf !== 1'b1) begin errors++; $display("FAIL sat_hold got %0d/%0b exp 15/1", result_count, result_ovf); end
  endtask

  task automatic test_abort();
    int nv, npost, ndone;
    nv = 0; npost = 0; ndone = 0;
    sweep_osc = 1'b1;
    drive_start(1'b0, 0, 50);
    for (int c = 1; c <= 170; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (result_valid) nv++;
      if (done) ndone++;
    end
    checks++; if (tap !== 4'd2 || busy !== 1'b1) begin errors++; $display("FAIL abort_pre tap %0d busy %0b exp 2/1", tap, busy); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", busy); end
    checks++; if (osc_enable !== 1'b0) begin errors++; $display("FAIL abort_osc_enable got %0b exp 0", osc_enable); end
    repeat (100) begin
      @(negedge clk);
      if (result_valid) npost++;
      if (done) ndone++;
    end
    checks++; if (nv !== 2) begin errors++; $display("FAIL abort_pre_valids got %0d exp 2", nv); end
    checks++; if (npost !== 0 || ndone !== 0) begin errors++; $display("FAIL abort_post got %0d valid %0d done exp 0/0", npost, ndone); end
    drive_start(1'b0, 0, 50);
    collect(700, 0);
    sweep_osc = 1'b0;
    checks++; if (v_cyc.size() !== 8) begin errors++; $display("FAIL abort_rerun_nvalid got %0d exp 8", v_cyc.size()); end
    if (v_cyc.size() == 8) begin
      checks++; if (v_tap[0] !== 0 || v_cyc[0] !== 67) begin errors++; $display("FAIL abort_rerun_first tap %0d cyc %0d exp 0/67", v_tap[0], v_cyc[0]); end
    end
  endtask

  task automatic test_corners();
    int nbusy;
    osc_period = 10;
    drive_start(1'b1, 3, 0);
    collect(100, 0);
    checks++; if (v_cyc.size() !== 1 || v_cyc[0] !== 18) begin errors++; $display("FAIL gate0_valid got %0d pulses exp 1 at 18", v_cyc.size()); end
    checks++; if (busy_low !== 19) begin errors++; $display("FAIL gate0_busy_low got %0d exp 19", busy_low); end

    drive_start(1'b1, 1, 20);
    collect(200, 10);
    checks++; if (v_cyc.size() !== 1 || v_cyc[0] !== 37) begin errors++; $display("FAIL restart_valid got %0d pulses exp 1 at 37", v_cyc.size()); end
    if (v_cyc.size() == 1) begin
      checks++; if (v_tap[0] !== 1) begin errors++; $display("FAIL restart_tap got %0d exp 1", v_tap[0]); end
    end
    checks++; if (busy_low !== 38) begin errors++; $display("FAIL restart_busy_low got %0d exp 38", busy_low); end

    nbusy = 0;
    @(negedge clk);
    single = 1'b1; tap_sel_in = TAP_W'(0); gate_cycles = GATE_W'(5);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (20) begin
      if (busy || osc_enable) nbusy++;
      @(negedge clk);
    end
    checks++; if (nbusy !== 0) begin errors++; $display("FAIL start_abort_busy got %0d cycles exp 0", nbusy); end

    drive_start(1'b1, 9, 10);
    collect(100, 0);
    checks++; if (v_cyc.size() !== 1 || v_cyc[0] !== 27) begin errors++; $display("FAIL clamp_valid got %0d pulses exp 1 at 27", v_cyc.size()); end
    if (v_cyc.size() == 1) begin
      checks++; if (v_tap[0] !== 7) begin errors++; $display("FAIL clamp_tap got %0d exp 7", v_tap[0]); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; single = 1'b0;
    tap_sel_in = '0; gate_cycles = '0;
    test_reset();
    test_single();
    test_sweep();
    test_saturation();
    test_abort();
    test_corners();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
